// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop rx synchronizer, mid-bit sampling, LSB-first data.
// Optional parity bit and parity_odd/parity_err ports under `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 baud_tick,
  input  logic                 rx,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_s1, rx_s2;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  logic wrap;
  assign wrap = baud_tick && (cnt == LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_valid <= 1'b0;
      case (state)
        // falling edge is seen without waiting for a tick
        IDLE: if (!rx_s2) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (baud_tick) begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: if (baud_tick) begin
          cnt <= wrap ? '0 : cnt + CW'(1);
          if (wrap) begin
            shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == BLAST) state <= PARITY;
`else
            if (bit_cnt == BLAST) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (baud_tick) begin
          cnt <= wrap ? '0 : cnt + CW'(1);
          if (wrap) begin
            par_bit <= rx_s2;
            state   <= STOP;
          end
        end
`endif
        STOP: if (baud_tick) begin
          cnt <= wrap ? '0 : cnt + CW'(1);
          if (wrap) begin
            rx_data   <= shreg;
            frame_err <= ~rx_s2;
            rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err <= (^shreg) ^ par_bit ^ parity_odd;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port baud_tick  input  1  one-clk oversample strobe from the baud generator.
REQ-006 SHALL have port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port rx_data  output  DATA_BITS  last received word, LSB = first data bit.
REQ-008 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-009 SHALL have port frame_err  output  1  stop bit of last frame sampled low; valid with rx_valid.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have ports parity_odd  input  1 and parity_err  output  1, present only under UART_RX_PARITY_EN.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY reachable only under UART_RX_PARITY_EN.
REQ-014 IDLE: on synchronized rx = 0, SHALL go to START, clear tick counter (width clog2(OVERSAMPLE)); no baud_tick needed.
REQ-015 Tick counter SHALL advance only on clk cycles with baud_tick = 1 and wrap OVERSAMPLE-1 -> 0.
REQ-016 START: at tick count OVERSAMPLE/2-1 SHALL sample rx; 0 -> clear counter, go DATA; 1 -> false start, back to IDLE, no output.
REQ-017 DATA: every OVERSAMPLE ticks (counter wrap at OVERSAMPLE-1) SHALL sample rx into shift register LSB first; after DATA_BITS samples go PARITY (if enabled) else STOP.
REQ-018 STOP: one bit period after last data/parity sample SHALL sample rx, load rx_data, set frame_err = ~rx, pulse rx_valid, return to IDLE in the same clk edge.
REQ-019 rx_valid SHALL be high exactly one clk cycle, on the cycle after the baud_tick edge that sampled the stop bit.
REQ-020 rx_data, frame_err, parity_err SHALL hold until the next rx_valid.
REQ-021 Stop bit low (break) SHALL still emit rx_valid with frame_err = 1 and the received data; FSM returns to IDLE and waits for rx high-then-low is not required (a low line re-enters START).
REQ-022 Back-to-back frames with one stop bit SHALL be received without loss.
REQ-023 baud_tick held low SHALL freeze the FSM in its current state (except the IDLE->START edge detect).

Reset
REQ-024 arst high SHALL immediately force state IDLE, counters 0, shift register 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, busy 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; no rx_valid after release until a complete new frame.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: one parity bit follows the data; expected parity even when parity_odd = 0, odd when 1; mismatch sets parity_err with rx_valid.
REQ-027 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity_odd/parity_err ports, frame = start + DATA_BITS + stop.

Verification (baud_tick every 3rd clk, OVERSAMPLE 16, DATA_BITS 8)
REQ-028 Frame 0xA5, stop high -> single rx_valid pulse, rx_data = 0xA5, frame_err = 0, busy low after.
REQ-029 rx low for 4 ticks then high -> no rx_valid, busy returns low within 8 ticks.
REQ-030 Frame 0x3C with stop bit low -> rx_valid, rx_data = 0x3C, frame_err = 1.
REQ-031 Frames 0x55 then 0xAA back-to-back -> two rx_valid pulses, data 0x55 then 0xAA, both frame_err = 0.
REQ-032 arst pulsed during data bit 3 of 0xFF -> all outputs 0 immediately; following frame 0x0F received correctly.
REQ-033 UART_RX_PARITY_EN, parity_odd = 1, data 0x01 with parity bit 1 -> parity_err = 1; parity bit 0 -> parity_err = 0.
